tape_out_uart: RTL

TAPE_OUT_UART -- requirements
Module: tape_out_uart

---
 rtl/tape_out_uart.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/tape_out_uart.sv
// tape_out_uart
//   Captures the cassette write level while the motor runs, encodes the time
//   between level edges as duration bytes (one unit = PRESCALE ce_4p ticks),
//   queues them in a byte FIFO and sends them out as 8N1 UART frames.
//
//   Byte encoding:
//     0x01..0xFF  duration of one level, in units (a sub-unit level reads 0x01)
//     0xFF        also emitted as a continuation when the unit counter saturates
//     0x00        terminator, emitted when the motor stops
//
// Ports
//   clk_sys     in   system clock
//   reset       in   synchronous, active-high reset
//   ce_4p       in   4 MHz clock enable, one clk_sys wide
//   tape_rec    in   cassette write level (clk_sys domain)
//   tape_motor  in   cassette motor relay state; capture runs only while 1
//   uart_tx     out  8N1 serial output, idle high
//   fifo_level  out  bytes currently queued
//   overflow    out  sticky: a byte was dropped because the FIFO was full
//   busy        out  a UART frame is in progress
//
// FIFO_DEPTH must be a power of two and at least 2.
module tape_out_uart #(
    parameter int unsigned BAUD_DIV   = 556,
    parameter int unsigned PRESCALE   = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        ce_4p,
    input  logic                        tape_rec,
    input  logic                        tape_motor,
    output logic                        uart_tx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    // ------------------------------------------------------------------
    // Capture: prescaler + unit counter, edge detection, byte generation
    // ------------------------------------------------------------------
    logic          motor_q;
    logic          rec_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    unit_q, unit_d;
    logic          tick_wrap;
    logic          unit_sat;
    logic          cap_push;
    logic [7:0]    cap_data;

    assign tick_wrap = ce_4p && (presc_q == PW'(PRESCALE - 1));
    // The unit counter would step past 255 on this tick.
    assign unit_sat  = tick_wrap && (unit_q == 8'hFF);

    always_comb begin
        cap_push = 1'b0;
        cap_data = 8'h00;
        presc_d  = presc_q;
        unit_d   = unit_q;
        if (!tape_motor) begin
            presc_d = '0;
            unit_d  = '0;
            // Motor just stopped: terminator byte.
            if (motor_q) begin
                cap_push = 1'b1;
            end
        end else if (!motor_q) begin
            // Motor just started; rec_q already tracks tape_rec, so no edge.
            presc_d = '0;
            unit_d  = '0;
        end else if (tape_rec != rec_q) begin
            // A coinciding saturation is folded into this single 0xFF.
            cap_push = 1'b1;
            if (unit_sat) begin
                cap_data = 8'hFF;
            end else if (unit_q == 8'h00) begin
                cap_data = 8'h01;
            end else begin
                cap_data = unit_q;
            end
            presc_d = '0;
            unit_d  = '0;
        end else if (tick_wrap) begin
            presc_d = '0;
            if (unit_sat) begin
                cap_push = 1'b1;
                cap_data = 8'hFF;
                unit_d   = '0;
            end else begin
                unit_d = unit_q + 8'd1;
            end
        end else if (ce_4p) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            motor_q <= 1'b0;
            rec_q   <= tape_rec;
            presc_q <= '0;
            unit_q  <= '0;
        end else begin
            motor_q <= tape_motor;
            rec_q   <= tape_rec;
            presc_q <= presc_d;
            unit_q  <= unit_d;
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q, count_d;
    logic          fifo_empty, fifo_full;
    logic          push_ok;
    logic          pop;
    logic [7:0]    rd_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == LW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push is about to use.
    assign push_ok    = cap_push && (!fifo_full || pop);
    assign rd_data    = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + LW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - LW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= cap_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            if (cap_push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    assign fifo_level = count_q;

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (baud_q == BW'(BAUD_DIV - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = rd_data;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    // Chain straight into the next frame to keep 10 bits per byte.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = rd_data;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Output is registered from the next state so it changes with the state.
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign uart_tx = tx_q;
    assign busy    = (state_q != StIdle);

endmodule
